// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of the decoder. It owns
// the 16-bit program counter, fetches one word at a time from instruction
// memory over a req/ack handshake, presents that word to the decoder with a
// valid flag (held while the decoder stalls) and redirects the PC whenever
// execute reports a taken branch.
//
// Ports:
//   i_clk        clock, every state update happens on the rising edge
//   i_rst        synchronous active-high reset
//   i_en         fetch enable; low stops new fetches from being issued
//   i_stall      decoder not ready; the presented word is held
//   i_br_take    taken-branch strobe (one cycle)
//   i_br_addr    branch target, sampled while i_br_take is high
//   o_mem_req    instruction memory request
//   o_mem_addr   request address, stable while o_mem_req is high
//   i_mem_ack    memory acknowledge; i_mem_data is valid in the same cycle
//   i_mem_data   instruction word returned by memory
//   o_inst       instruction presented to the decoder
//   o_inst_valid o_inst holds a word for the decoder
//   o_pc         address that o_inst was fetched from
//   o_fault      sticky fetch timeout fault
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a watchdog counts FETCH cycles without an
//                     ack and enters FAULT after MEM_TIMEOUT of them. When
//                     undefined, FETCH waits forever and o_fault is tied low.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_stall,
  input  logic        i_br_take,
  input  logic [15:0] i_br_addr,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data,
  output logic [15:0] o_inst,
  output logic        o_inst_valid,
  output logic [15:0] o_pc,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        kill_q, kill_d;
  logic [15:0] redirect;
  logic        timeout_hit;

  // Address following the word currently on the bus; 16-bit arithmetic so
  // 16'hFFFF naturally wraps to 16'h0000.
  logic [15:0] next_seq_addr;
  assign next_seq_addr = mem_addr_q + STEP;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TLIMIT = 16'(MEM_TIMEOUT - 1);

  logic [15:0] tcount_q, tcount_d;
  logic        fault_q;

  // The watchdog fires on the last allowed waiting cycle, so the request is
  // visible for exactly MEM_TIMEOUT cycles before it is dropped.
  assign timeout_hit = (tcount_q >= TLIMIT);

  // Count only cycles that stay in FETCH without an ack; any ack (including a
  // discarded one that re-issues) or leaving FETCH starts the count over.
  always_comb begin
    tcount_d = 16'h0000;
    if ((state_q == FETCH) && (state_d == FETCH) && !i_mem_ack) begin
      tcount_d = tcount_q + 16'h0001;
    end
  end

  // Watchdog count and the sticky fault flag, which simply mirrors entry
  // into the FAULT state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcount_q <= 16'h0000;
      fault_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      fault_q  <= (state_d == FAULT);
    end
  end

  assign o_fault = fault_q;
`else
  // Without the watchdog a request may wait indefinitely; the limit is only
  // referenced here so the parameter keeps the same meaning in both builds.
  assign timeout_hit = (MEM_TIMEOUT == 0) & 1'b0;
  assign o_fault     = 1'b0;
`endif

  // Next-state and next-output logic. A taken branch outranks every other
  // event except reset; in FAULT it is ignored because FAULT is left only
  // through reset.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    kill_d       = kill_q;
    redirect     = pc_q;

    case (state_q)
      IDLE: begin
        if (i_br_take) begin
          pc_d         = i_br_addr;
          inst_valid_d = 1'b0;
          if (i_en) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = i_br_addr;
          end
        end else if (i_en) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (i_mem_ack) begin
          if (kill_q || i_br_take) begin
            // The returning word belongs to the old path: drop it and
            // restart at the branch target held in pc (or arriving now).
            kill_d = 1'b0;
            if (i_br_take) begin
              pc_d     = i_br_addr;
              redirect = i_br_addr;
            end
            inst_valid_d = 1'b0;
            if (i_en) begin
              mem_req_d  = 1'b1;
              mem_addr_d = redirect;
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
            end
          end else begin
            inst_d       = i_mem_data;
            inst_pc_d    = mem_addr_q;
            inst_valid_d = 1'b1;
            pc_d         = next_seq_addr;
            mem_req_d    = 1'b0;
            state_d      = HOLD;
          end
        end else if (i_br_take) begin
          // The request cannot be withdrawn, so remember to discard its data.
          pc_d         = i_br_addr;
          inst_valid_d = 1'b0;
          kill_d       = 1'b1;
        end else if (timeout_hit) begin
          state_d   = FAULT;
          mem_req_d = 1'b0;
        end
      end

      HOLD: begin
        if (i_br_take) begin
          // Any simultaneous transfer still counts; the branch only decides
          // where the next fetch goes.
          pc_d         = i_br_addr;
          inst_valid_d = 1'b0;
          if (i_en) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = i_br_addr;
          end else begin
            state_d = IDLE;
          end
        end else if (!i_stall) begin
          inst_valid_d = 1'b0;
          if (i_en) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FAULT: begin
        mem_req_d    = 1'b0;
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_q       <= 16'h0000;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_pc         = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A memory responder answers requests
// after a programmable latency with a data word derived from the address.
// A transaction-level model tracks the outstanding request, whether it has
// been overtaken by a branch, the word waiting for the decoder and where the
// next fetch must go; every cycle the DUT outputs are compared against it.
// Directed sequences add hand-computed literal expectations.
// Honours FETCH_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          PC_STEP     = 1;
  localparam int          MEM_TIMEOUT = 15;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_br_take = 1'b0;
  logic [15:0] i_br_addr = 16'h0000;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic [15:0] o_inst;
  logic        o_inst_valid;
  logic [15:0] o_pc;
  logic        o_fault;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int mem_lat   = 1;
  bit ack_block = 1'b0;
  bit force_ack = 1'b0;
  int wait_cnt  = 0;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .PC_STEP    (PC_STEP),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_stall     (i_stall),
    .i_br_take   (i_br_take),
    .i_br_addr   (i_br_addr),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_inst      (o_inst),
    .o_inst_valid(o_inst_valid),
    .o_pc        (o_pc),
    .o_fault     (o_fault)
  );

  always #5 i_clk = ~i_clk;

  // Memory contents: byte-swapped address xor a fixed pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory responder: acks once the request has waited mem_lat cycles;
  // force_ack injects a stray ack regardless of the request.
  assign i_mem_ack  = (o_mem_req && (wait_cnt >= mem_lat) && !ack_block) || force_ack;
  assign i_mem_data = mem_word(o_mem_addr);

  always @(posedge i_clk) begin
    wait_cnt <= (o_mem_req && !i_mem_ack) ? wait_cnt + 1 : 0;
  end

  // Transaction-level reference model, advanced once per rising edge.
  bit          m_busy  = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_have  = 1'b0;
  bit          m_fault = 1'b0;
  int          m_wait  = 0;
  logic [15:0] m_addr  = RESET_PC;
  logic [15:0] m_next  = RESET_PC;
  logic [15:0] m_word  = 16'h0000;
  logic [15:0] m_wpc   = RESET_PC;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_have  = 1'b0;
      m_fault = 1'b0;
      m_wait  = 0;
      m_addr  = RESET_PC;
      m_next  = RESET_PC;
    end else if (!m_fault) begin
      if ((m_have && !i_stall) || i_br_take) m_have = 1'b0;
      if (m_busy) begin
        if (i_mem_ack) begin
          m_busy = 1'b0;
          m_wait = 0;
          if (!m_stale && !i_br_take) begin
            m_have = 1'b1;
            m_word = mem_word(m_addr);
            m_wpc  = m_addr;
            m_next = 16'(m_addr + PC_STEP);
          end
          m_stale = 1'b0;
        end else begin
          m_wait++;
          if (i_br_take) m_stale = 1'b1;
          else if (TIMEOUT_ON && m_wait >= MEM_TIMEOUT) begin
            m_fault = 1'b1;
            m_busy  = 1'b0;
            m_stale = 1'b0;
          end
        end
      end
      if (i_br_take) m_next = i_br_addr;
      if (!m_fault && !m_busy && !m_have && i_en) begin
        m_busy = 1'b1;
        m_addr = m_next;
        m_wait = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit stall, input bit br, input logic [15:0] addr);
    i_en      = en;
    i_stall   = stall;
    i_br_take = br;
    i_br_addr = addr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // which: 0 = wait for o_inst_valid, 1 = wait for o_mem_req
  task automatic waitUntil(input int which, input int bound, input string name);
    bit hit;
    hit = (which == 0) ? o_inst_valid : o_mem_req;
    for (int i = 0; i < bound && !hit; i++) begin
      tick(1);
      hit = (which == 0) ? o_inst_valid : o_mem_req;
    end
    checkOutput(name, 16'(hit), 16'h0001);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    ack_block = 1'b0;
    tick(12);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      checkOutput("model_req", 16'(o_mem_req), 16'(m_busy));
      if (m_busy) checkOutput("model_addr", o_mem_addr, m_addr);
      checkOutput("model_valid", 16'(o_inst_valid), 16'(m_have));
      if (m_have) begin
        checkOutput("model_inst", o_inst, m_word);
        checkOutput("model_pc", o_pc, m_wpc);
      end
      checkOutput("model_fault", 16'(o_fault), 16'(m_fault));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pcs[5];
    logic [15:0] insts[5];
    int          when[5];
    int          got;
    int          hi;
    int          seen;
    logic [15:0] cap_inst, cap_pc, old_addr;

    // Reset values.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    i_rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    checkOutput("rst_req", 16'(o_mem_req), 16'h0000);
    checkOutput("rst_addr", o_mem_addr, 16'h0000);
    checkOutput("rst_inst", o_inst, 16'h0000);
    checkOutput("rst_valid", 16'(o_inst_valid), 16'h0000);
    checkOutput("rst_pc", o_pc, 16'h0000);
    checkOutput("rst_fault", 16'(o_fault), 16'h0000);

    // Sequential fetch: three words with one-cycle memory, then two zero-wait.
    i_rst   = 1'b0;
    mem_lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      tick(1);
      if (o_inst_valid) begin
        pcs[got]   = o_pc;
        insts[got] = o_inst;
        when[got]  = c;
        got++;
        if (got == 3) mem_lat = 0;
      end
    end
    checkOutput("seq_count", 16'(got), 16'd5);
    if (got == 5) begin
      checkOutput("seq_pc0", pcs[0], 16'h0000);
      checkOutput("seq_pc1", pcs[1], 16'h0001);
      checkOutput("seq_pc2", pcs[2], 16'h0002);
      checkOutput("seq_pc4", pcs[4], 16'h0004);
      checkOutput("seq_inst0", insts[0], 16'h5A3C);
      checkOutput("seq_inst1", insts[1], 16'h5B3C);
      checkOutput("seq_inst2", insts[2], 16'h583C);
      checkOutput("seq_inst3", insts[3], 16'h593C);
      checkOutput("seq_inst4", insts[4], 16'h5E3C);
      checkOutput("seq_gap_lat1", 16'(when[2] - when[1]), 16'd3);
      checkOutput("seq_gap_lat0", 16'(when[4] - when[3]), 16'd2);
    end

    // Decoder stall for four cycles holds the word and blocks new requests.
    waitUntil(0, 10, "stall_reach_valid");
    cap_inst = o_inst;
    cap_pc   = o_pc;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("stall_inst", o_inst, cap_inst);
      checkOutput("stall_pc", o_pc, cap_pc);
      checkOutput("stall_req", 16'(o_mem_req), 16'h0000);
      checkOutput("stall_valid", 16'(o_inst_valid), 16'h0001);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(1);
    checkOutput("stall_after_valid", 16'(o_inst_valid), 16'h0000);
    checkOutput("stall_after_req", 16'(o_mem_req), 16'h0001);
    checkOutput("stall_after_addr", o_mem_addr, 16'(cap_pc + 16'h0001));

    // Branch while a slow fetch is outstanding: its word is dropped.
    drain();
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    waitUntil(1, 10, "br_reach_req");
    old_addr = o_mem_addr;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    seen = 0;
    for (int i = 0; i < 20 && !(o_mem_req && o_mem_addr != old_addr); i++) begin
      if (o_inst_valid) seen++;
      tick(1);
    end
    checkOutput("br_next_addr", o_mem_addr, 16'h0040);
    checkOutput("br_dropped", 16'(seen), 16'h0000);
    waitUntil(0, 20, "br_reach_valid");
    checkOutput("br_pc", o_pc, 16'h0040);
    checkOutput("br_inst", o_inst, 16'h1A3C);

    // Fetch at 16'hFFFF wraps the next request to 16'h0000.
    drain();
    mem_lat = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    waitUntil(0, 10, "wrap_reach_valid");
    checkOutput("wrap_pc", o_pc, 16'hFFFF);
    checkOutput("wrap_inst", o_inst, 16'hA5C3);
    tick(1);
    checkOutput("wrap_req", 16'(o_mem_req), 16'h0001);
    checkOutput("wrap_addr", o_mem_addr, 16'h0000);

    // Memory never answers.
    drain();
    ack_block = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    waitUntil(1, 5, "to_reach_req");
    hi = 0;
    while (o_mem_req && hi < 40) begin
      hi++;
      tick(1);
    end
`ifdef FETCH_TIMEOUT_EN
    checkOutput("to_req_cycles", 16'(hi), 16'd15);
    checkOutput("to_fault", 16'(o_fault), 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0123);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(3);
    checkOutput("to_fault_sticky", 16'(o_fault), 16'h0001);
    checkOutput("to_req_low", 16'(o_mem_req), 16'h0000);
    ack_block = 1'b0;
    i_rst = 1'b1;
    tick(1);
    checkOutput("to_rst_fault", 16'(o_fault), 16'h0000);
    i_rst = 1'b0;
    tick(1);
    checkOutput("to_rst_req", 16'(o_mem_req), 16'h0001);
    checkOutput("to_rst_addr", o_mem_addr, RESET_PC);
`else
    checkOutput("nto_still_waiting", 16'(hi), 16'd40);
    checkOutput("nto_fault", 16'(o_fault), 16'h0000);
    ack_block = 1'b0;
`endif

    // Reset while a request waits for ack; a late ack is ignored.
    drain();
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    waitUntil(1, 10, "rm_reach_req");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    i_rst = 1'b1;
    tick(1);
    checkOutput("rm_req", 16'(o_mem_req), 16'h0000);
    i_rst     = 1'b0;
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rm_no_valid", 16'(o_inst_valid), 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
